// File: rtl/down_counter_if.sv
// Control/status bundle for the loadable countdown timer.
//   start    : load request, master -> counter
//   load_val : initial count captured with start, master -> counter
//   en       : count enable, master -> counter
//   count    : current count value, counter -> master
//   busy     : counter is decrementing (RUN), counter -> master
//   done     : single-cycle terminal-count flag, counter -> master
interface down_counter_if #(
    parameter int unsigned WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    // Requester side: issues loads and enables, observes status.
    modport master (
        output start,
        output load_val,
        output en,
        input  count,
        input  busy,
        input  done
    );

    // Timer side: consumes loads and enables, reports status.
    modport slave (
        input  start,
        input  load_val,
        input  en,
        output count,
        output busy,
        output done
    );
endinterface : down_counter_if

// File: rtl/down_counter.sv
// Loadable countdown timer.
// A start pulse loads load_val; the count then decrements once per enabled
// clock while in RUN. Reaching zero moves to DONE, which raises done for
// exactly one cycle before returning to IDLE. A zero load goes straight to
// DONE, so RUN is never entered with count==0 and the count cannot underflow.
// Ports:
//   clk : system clock, all logic on posedge
//   rst : synchronous reset, active-high, priority over all inputs
//   bus : down_counter_if slave modport (start/load_val/en in,
//         count/busy/done out, all outputs registered)
module down_counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    down_counter_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-count logic; start has priority over en everywhere.
    always_comb begin
        state_d = state_q;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    count_d = bus.load_val;
                    state_d = (bus.load_val != '0) ? ST_RUN : ST_DONE;
                end
            end

            ST_RUN: begin
                if (bus.start) begin
                    count_d = bus.load_val;
                    state_d = (bus.load_val != '0) ? ST_RUN : ST_DONE;
                end else if (bus.en) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // Last decrement lands on zero; terminal count.
                        count_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (bus.start) begin
                    count_d = bus.load_val;
                    state_d = (bus.load_val != '0) ? ST_RUN : ST_DONE;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Moore flags registered alongside the state they decode.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule : down_counter
